// File: rtl/rv32i_mem_pkg.sv
// Shared types and helpers for the rv32i memory interface slice.
package rv32i_mem_pkg;

    typedef enum logic [1:0] {
        MEM_B    = 2'b00,
        MEM_H    = 2'b01,
        MEM_W    = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

    function automatic logic [3:0] byte_lanes(input mem_size_t size, input logic [1:0] offset);
        case (size)
            MEM_B:   byte_lanes = 4'b0001 << offset;
            MEM_H:   byte_lanes = 4'b0011 << offset;
            MEM_W:   byte_lanes = 4'b1111;
            default: byte_lanes = 4'b0000;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            MEM_B:   is_misaligned = 1'b0;
            MEM_H:   is_misaligned = offset[0];
            MEM_W:   is_misaligned = (offset != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Load extraction: shifts the addressed byte/half of a raw word down to bit 0
// and sign- or zero-extends it. Purely combinational.
module rv32i_load_align
    import rv32i_mem_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  mem_size_t   size_i,
    input  logic        unsigned_i,
    input  logic [31:0] word_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = word_i >> {offset_i, 3'b000};

    always_comb begin
        data_o = word_i;
        case (size_i)
            MEM_B:   data_o = {{24{~unsigned_i & shifted[7]}},  shifted[7:0]};
            MEM_H:   data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/rv32i_mem_if.sv
// Word-organised RAM serving a registered instruction port and a byte/half/word data port.
// Optional RV32I_MEM_IF_RANGE_CHECK_EN: out-of-range addresses fault instead of aliasing.
module rv32i_mem_if
    import rv32i_mem_pkg::*;
#(
    parameter int    ADDR_WIDTH = 10,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] if_addr,
    output logic [31:0] if_data,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    input  logic        d_re,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    output logic [31:0] d_rdata,
    output logic        d_misaligned
);

    logic [31:0] mem_q [2**ADDR_WIDTH];

    mem_size_t             size_e;
    logic [ADDR_WIDTH-1:0] d_idx;
    logic [ADDR_WIDTH-1:0] if_idx;
    logic                  d_mis;
    logic                  d_oor;
    logic                  if_oor;
    logic                  store_en;
    logic [3:0]            lanes;
    logic [31:0]           wdata_rep;

    assign size_e = mem_size_t'(d_size);
    assign d_idx  = d_addr[ADDR_WIDTH+1:2];
    assign if_idx = if_addr[ADDR_WIDTH-1:0];
    assign d_mis  = is_misaligned(size_e, d_addr[1:0]);
    assign lanes  = byte_lanes(size_e, d_addr[1:0]);

`ifdef RV32I_MEM_IF_RANGE_CHECK_EN
    assign d_oor  = |d_addr[31:ADDR_WIDTH+2];
    assign if_oor = |if_addr[29:ADDR_WIDTH];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{d_addr[31:ADDR_WIDTH+2], if_addr[29:ADDR_WIDTH]};
    assign d_oor  = 1'b0;
    assign if_oor = 1'b0;
`endif

    assign store_en = d_we & ~d_mis & ~d_oor & ~reset;

    always_comb begin
        wdata_rep = d_wdata;
        case (size_e)
            MEM_B:   wdata_rep = {4{d_wdata[7:0]}};
            MEM_H:   wdata_rep = {2{d_wdata[15:0]}};
            default: wdata_rep = d_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int l = 0; l < 4; l++) begin
                if (lanes[l]) mem_q[d_idx][8*l +: 8] <= wdata_rep[8*l +: 8];
            end
        end
    end

    // Load response register: raw word plus extraction controls; d_rdata is derived from
    // these, so it holds whenever no new load is accepted.
    logic [31:0] if_data_q;
    logic [31:0] raw_q;
    logic [1:0]  off_q;
    mem_size_t   size_q;
    logic        uns_q;
    logic        mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_data_q <= RV32I_NOP;
            raw_q     <= '0;
            off_q     <= 2'b00;
            size_q    <= MEM_W;
            uns_q     <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            if_data_q <= if_oor ? RV32I_NOP : mem_q[if_idx];
            mis_q     <= (d_we | d_re) & (d_mis | d_oor);
            if (d_re && !d_we && !d_mis) begin
                raw_q  <= d_oor ? 32'h0 : mem_q[d_idx];
                off_q  <= d_addr[1:0];
                size_q <= d_oor ? MEM_W : size_e;
                uns_q  <= d_unsigned;
            end
        end
    end

    rv32i_load_align u_load_align (
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .word_i     (raw_q),
        .data_o     (d_rdata)
    );

    assign if_data      = if_data_q;
    assign d_misaligned = mis_q;

endmodule
